// File: rtl/dma_2d_pkg.sv
// Shared types and constants for the 2D DMA burst-command generator.
// Holds the FSM state encoding, AXI field widths and beat-size helpers.
package dma_2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int AXI_LEN_W = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    // AXI AxSIZE encoding is log2 of the bytes per beat.
    function automatic logic [2:0] axi_size_code(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/dma_2d_burst_len_calc.sv
// Burst length selection: smallest of beats left in the line, the maximum
// AXI burst, and the beats that fit before the next address boundary.
module dma_2d_burst_len_calc
    import dma_2d_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DIM_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int BOUNDARY      = 4096
) (
    input  logic [DIM_WIDTH-1:0]  beats_left_i,
    input  logic [ADDR_WIDTH-1:0] cur_addr_i,
    output logic [AXI_LEN_W:0]    n_o
);

    localparam int BYTES    = bytes_per_beat(DATA_WIDTH);
    localparam int BYTE_LOG = $clog2(BYTES);
    localparam int BND_LOG  = $clog2(BOUNDARY);
    localparam int CW       = ((DIM_WIDTH > BND_LOG) ? DIM_WIDTH : BND_LOG) + 1;

    logic [CW-1:0] room_beats;
    logic [CW-1:0] beats_ext;
    logic [CW-1:0] max_ext;
    logic [CW-1:0] min_bl;
    logic [CW-1:0] min_all;
    logic [BND_LOG-1:0] bnd_off;
    logic unused_addr_hi;

    // Only the offset inside the current boundary window matters.
    assign bnd_off        = cur_addr_i[BND_LOG-1:0];
    assign unused_addr_hi = ^cur_addr_i[ADDR_WIDTH-1:BND_LOG];

    assign room_beats = CW'(BOUNDARY >> BYTE_LOG) - CW'(bnd_off >> BYTE_LOG);
    assign beats_ext  = CW'(beats_left_i);
    assign max_ext    = CW'(MAX_BURST_LEN);

    always_comb begin
        min_bl  = (beats_ext < max_ext) ? beats_ext : max_ext;
        min_all = (min_bl < room_beats) ? min_bl : room_beats;
        n_o     = (AXI_LEN_W + 1)'(min_all);
    end

endmodule

// File: rtl/dma_2d_burst_gen.sv
// 2D burst-command generator: walks a frame descriptor line by line and
// emits AXI burst commands split at MAX_BURST_LEN and BOUNDARY crossings.
module dma_2d_burst_gen
    import dma_2d_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DIM_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int BOUNDARY      = 4096
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [DIM_WIDTH-1:0]  i_width,
    input  logic [DIM_WIDTH-1:0]  i_height,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [AXI_LEN_W-1:0]  o_cmd_len,
    output logic                  o_cmd_eol,
    output logic                  o_cmd_last
);

    localparam int BYTES    = bytes_per_beat(DATA_WIDTH);
    localparam int BYTE_LOG = $clog2(BYTES);
    localparam int NW       = AXI_LEN_W + 1;
    localparam int EW       = (DIM_WIDTH > NW) ? DIM_WIDTH : NW;

    state_e                state_q;
    logic [DIM_WIDTH-1:0]  width_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [DIM_WIDTH-1:0]  beats_left_q;
    logic [DIM_WIDTH-1:0]  lines_left_q;
    logic [NW-1:0]         n_q;

    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [AXI_LEN_W-1:0]  cmd_len_q;
    logic                  cmd_eol_q;
    logic                  cmd_last_q;

    logic [NW-1:0]         n_d;
    logic                  eol_d;
    logic                  last_d;
    logic [ADDR_WIDTH-1:0] next_line_addr_d;
    logic [ADDR_WIDTH-1:0] next_cur_addr_d;

    dma_2d_burst_len_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DIM_WIDTH     (DIM_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BOUNDARY      (BOUNDARY)
    ) u_len_calc (
        .beats_left_i (beats_left_q),
        .cur_addr_i   (cur_addr_q),
        .n_o          (n_d)
    );

    assign eol_d            = (EW'(n_d) == EW'(beats_left_q));
    assign last_d           = eol_d && (lines_left_q == DIM_WIDTH'(1));
    assign next_line_addr_d = line_addr_q + stride_q;
    assign next_cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(n_q) << BYTE_LOG);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            width_q      <= '0;
            stride_q     <= '0;
            line_addr_q  <= '0;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            lines_left_q <= '0;
            n_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cmd_eol_q    <= 1'b0;
            cmd_last_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        width_q      <= i_width;
                        stride_q     <= i_stride;
                        line_addr_q  <= i_base_addr;
                        cur_addr_q   <= i_base_addr;
                        beats_left_q <= i_width;
                        lines_left_q <= i_height;
                        busy_q       <= 1'b1;
                        // An empty frame still reports completion, just without commands.
                        if ((i_width == '0) || (i_height == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    n_q        <= n_d;
                    cmd_addr_q <= cur_addr_q;
                    cmd_len_q  <= AXI_LEN_W'(n_d - NW'(1));
                    cmd_eol_q  <= eol_d;
                    cmd_last_q <= last_d;
                    valid_q    <= 1'b1;
                    state_q    <= ISSUE;
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        valid_q <= 1'b0;
                        if (!cmd_eol_q) begin
                            cur_addr_q   <= next_cur_addr_d;
                            beats_left_q <= beats_left_q - DIM_WIDTH'(n_q);
                            state_q      <= CALC;
                        end else if (!cmd_last_q) begin
                            line_addr_q  <= next_line_addr_d;
                            cur_addr_q   <= next_line_addr_d;
                            beats_left_q <= width_q;
                            lines_left_q <= lines_left_q - DIM_WIDTH'(1);
                            state_q      <= CALC;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_cmd_valid = valid_q;
    assign o_cmd_addr  = cmd_addr_q;
    assign o_cmd_len   = cmd_len_q;
    assign o_cmd_eol   = cmd_eol_q;
    assign o_cmd_last  = cmd_last_q;

endmodule

// File: tb/tb_dma_2d_burst_gen.sv
// Self-checking bench for dma_2d_burst_gen: directed frames plus randomized
// frames and ready patterns, compared against a queue-based reference model.
module tb_dma_2d_burst_gen;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DIMW  = 16;
    localparam int MBL   = 16;
    localparam int BND   = 4096;
    localparam int BYTES = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          eol;
        logic          last;
    } cmd_t;

    logic            aclk = 1'b0;
    logic            areset;
    logic            i_start;
    logic [AW-1:0]   i_base_addr;
    logic [DIMW-1:0] i_width;
    logic [DIMW-1:0] i_height;
    logic [AW-1:0]   i_stride;
    logic            o_busy;
    logic            o_done;
    logic            o_cmd_valid;
    logic            i_cmd_ready;
    logic [AW-1:0]   o_cmd_addr;
    logic [7:0]      o_cmd_len;
    logic            o_cmd_eol;
    logic            o_cmd_last;

    cmd_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 aclk = ~aclk;

    dma_2d_burst_gen #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .DIM_WIDTH     (DIMW),
        .MAX_BURST_LEN (MBL),
        .BOUNDARY      (BND)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_width     (i_width),
        .i_height    (i_height),
        .i_stride    (i_stride),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_len   (o_cmd_len),
        .o_cmd_eol   (o_cmd_eol),
        .o_cmd_last  (o_cmd_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected command list straight from the frame walk: every line is cut
    // into bursts of min(remaining, MBL, beats until the next BND boundary).
    function automatic void build_model(input logic [AW-1:0] base, input int w, input int h,
                                        input logic [AW-1:0] stride);
        logic [AW-1:0] line_a;
        logic [AW-1:0] a;
        int            rem;
        int            room;
        int            n;
        cmd_t          c;
        exp_q.delete();
        line_a = base;
        for (int l = 0; l < h; l++) begin
            a   = line_a;
            rem = w;
            while (rem > 0) begin
                room = (BND - int'(a % 32'(BND))) / BYTES;
                n    = rem;
                if (n > MBL)  n = MBL;
                if (n > room) n = room;
                c.addr = a;
                c.len  = 8'(n - 1);
                c.eol  = (n == rem);
                c.last = c.eol && (l == h - 1);
                exp_q.push_back(c);
                a   = a + 32'(n * BYTES);
                rem = rem - n;
            end
            line_a = line_a + stride;
        end
    endfunction

    // rmode: 0 ready always high, 1 random ready, 2 ready low for cycles 3..7
    task automatic run_frame(input logic [AW-1:0] base, input int w, input int h,
                             input logic [AW-1:0] stride, input int rmode, input bit noise);
        int   cyc        = 0;
        int   first_v    = -1;
        int   last_acc   = -1;
        int   done_cyc   = -1;
        bit   done_seen  = 0;
        bit   stall      = 0;
        bit   rdy;
        int   off;
        cmd_t held;
        cmd_t e;
        build_model(base, w, h, stride);
        @(negedge aclk);
        i_base_addr = base;
        i_width     = DIMW'(w);
        i_height    = DIMW'(h);
        i_stride    = stride;
        i_start     = 1'b1;
        @(negedge aclk);
        i_start = 1'b0;
        while (!done_seen && cyc < 2000) begin
            check("busy_in_frame", 64'(o_busy), 64'(1));
            if (stall) begin
                check("hold_valid", 64'(o_cmd_valid), 64'(1));
                check("hold_addr", 64'(o_cmd_addr), 64'(held.addr));
                check("hold_len", 64'(o_cmd_len), 64'(held.len));
                check("hold_eol", 64'(o_cmd_eol), 64'(held.eol));
                check("hold_last", 64'(o_cmd_last), 64'(held.last));
            end
            if (o_cmd_valid && first_v < 0) first_v = cyc;
            if (o_done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 6);
                default: rdy = !(cyc >= 3 && cyc <= 7);
            endcase
            if (o_cmd_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_cmd", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", 64'(o_cmd_addr), 64'(e.addr));
                    check("cmd_len", 64'(o_cmd_len), 64'(e.len));
                    check("cmd_eol", 64'(o_cmd_eol), 64'(e.eol));
                    check("cmd_last", 64'(o_cmd_last), 64'(e.last));
                end
                off = int'(o_cmd_addr % 32'(BND));
                check("no_bnd_cross", 64'((off + (int'(o_cmd_len) + 1) * BYTES) > BND), 64'(0));
                last_acc = cyc;
                stall    = 0;
            end else if (o_cmd_valid) begin
                stall      = 1;
                held.addr  = o_cmd_addr;
                held.len   = o_cmd_len;
                held.eol   = o_cmd_eol;
                held.last  = o_cmd_last;
            end else begin
                stall = 0;
            end
            i_cmd_ready = rdy;
            if (noise && !done_seen) begin
                i_base_addr = $urandom;
                i_width     = DIMW'($urandom);
                i_height    = DIMW'($urandom);
                i_stride    = $urandom;
                i_start     = 1'($urandom_range(0, 1));
            end else begin
                i_start = 1'b0;
            end
            @(negedge aclk);
            cyc++;
        end
        i_start     = 1'b0;
        i_cmd_ready = 1'b1;
        check("frame_timeout", 64'(!done_seen), 64'(0));
        check("cmd_count_left", 64'(exp_q.size()), 64'(0));
        if (w == 0 || h == 0) begin
            check("no_valid_empty", 64'(first_v), 64'(-1));
            check("done_lat_empty", 64'(done_cyc), 64'(0));
        end else begin
            check("first_valid_lat", 64'(first_v), 64'(1));
            check("done_lat", 64'(done_cyc), 64'(last_acc + 1));
        end
        check("done_pulse_end", 64'(o_done), 64'(0));
        check("busy_end", 64'(o_busy), 64'(0));
        check("valid_end", 64'(o_cmd_valid), 64'(0));
    endtask

    initial begin
        logic [AW-1:0] base;
        logic [AW-1:0] r;
        int            wait_cyc;

        areset      = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_width     = '0;
        i_height    = '0;
        i_stride    = '0;
        i_cmd_ready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_valid", 64'(o_cmd_valid), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_addr", 64'(o_cmd_addr), 64'(0));
        check("rst_len", 64'(o_cmd_len), 64'(0));
        check("rst_eol", 64'(o_cmd_eol), 64'(0));
        check("rst_last", 64'(o_cmd_last), 64'(0));
        areset = 1'b0;

        run_frame(32'h0000_1000, 16, 1, 32'h0, 0, 0);
        run_frame(32'h0000_0000, 40, 2, 32'h200, 0, 0);
        run_frame(32'h0000_0FF0, 16, 1, 32'h0, 0, 0);
        run_frame(32'h0000_0000, 40, 2, 32'h200, 2, 0);

        // Empty frame with i_start held across the DONE cycle.
        @(negedge aclk);
        i_base_addr = 32'h0;
        i_width     = 16'd0;
        i_height    = 16'd3;
        i_start     = 1'b1;
        @(negedge aclk);
        check("empty_done", 64'(o_done), 64'(1));
        check("empty_busy", 64'(o_busy), 64'(1));
        check("empty_valid", 64'(o_cmd_valid), 64'(0));
        i_width  = 16'd16;
        i_height = 16'd1;
        @(negedge aclk);
        i_start = 1'b0;
        check("empty_done_1cyc", 64'(o_done), 64'(0));
        check("empty_idle", 64'(o_busy), 64'(0));
        repeat (4) begin
            @(negedge aclk);
            check("busy_start_ignored", 64'(o_busy | o_cmd_valid), 64'(0));
        end
        run_frame(32'h0000_0000, 0, 3, 32'h100, 0, 1);

        // Reset in the middle of a frame with a command pending.
        @(negedge aclk);
        i_base_addr = 32'h0;
        i_width     = 16'd40;
        i_height    = 16'd2;
        i_stride    = 32'h200;
        i_start     = 1'b1;
        i_cmd_ready = 1'b0;
        @(negedge aclk);
        i_start  = 1'b0;
        wait_cyc = 0;
        while (!o_cmd_valid && wait_cyc < 20) begin
            @(negedge aclk);
            wait_cyc++;
        end
        check("pre_reset_valid", 64'(o_cmd_valid), 64'(1));
        areset = 1'b1;
        @(negedge aclk);
        areset      = 1'b0;
        i_cmd_ready = 1'b1;
        check("midrst_valid", 64'(o_cmd_valid), 64'(0));
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_done", 64'(o_done), 64'(0));
        run_frame(32'h0000_0000, 40, 2, 32'h200, 0, 0);

        // Address wrap across the top of the address space.
        run_frame(32'hFFFF_FFC0, 40, 2, 32'h100, 1, 1);

        for (int k = 0; k < 12; k++) begin
            r = $urandom;
            if (k % 2 == 0)
                base = (r & 32'hFFFF_F000) | (32'hFFC - 32'(4 * $urandom_range(0, 20)));
            else
                base = r & 32'hFFFF_FFFC;
            run_frame(base, $urandom_range(1, 70), $urandom_range(1, 4),
                      32'($urandom_range(0, 4096) * 4), 1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
